instruction_fetch_unit: RTL



---
 rtl/instruction_fetch_unit.sv | 97 +++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues fetch addresses and captures returned
// words into the IF/ID register, with stall replay, branch redirect/flush and halt.
module instruction_fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] PC_STEP   = 16'd2,
  parameter logic [15:0] HALT_WORD = 16'hEFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr_in,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic [15:0] pc_out,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc,
  output logic        if_id_valid,
  output logic        halted,
  output logic [15:0] fetch_count,
  output logic        fsm_state
);

  // Handshake: memory answers every address unconditionally one cycle later; stall
  // replays pc_q so the in-flight word stays on instr_in until the stall drops.
  typedef enum logic {FETCH = 1'b0, HALT = 1'b1} state_t;

  state_t      state, state_n;
  logic [15:0] pc, pc_n, pc_q, pc_q_n;
  logic        inflight, inflight_n;
  logic [15:0] instr_n, ipc_n, count_n;
  logic        valid_n, halted_n;

  assign pc_out    = (state == FETCH && stall) ? pc_q : pc;
  assign fsm_state = state;

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    pc_q_n     = pc_q;
    inflight_n = inflight;
    instr_n    = if_id_instr;
    ipc_n      = if_id_pc;
    valid_n    = if_id_valid;
    halted_n   = halted;
    count_n    = fetch_count;
    if (state == HALT) begin
      valid_n = 1'b0;
    end else if (branch_taken) begin
      pc_n       = branch_target;
      inflight_n = 1'b0;
      valid_n    = 1'b0;
    end else if (!stall) begin
      valid_n = 1'b0;
      if (inflight) begin
        instr_n = instr_in;
        ipc_n   = pc_q;
        valid_n = 1'b1;
        if (fetch_count != 16'hFFFF) count_n = fetch_count + 16'd1;
      end
      // A halt capture stops issuing: pc keeps the address after the halt word.
      if (inflight && instr_in == HALT_WORD) begin
        state_n    = HALT;
        halted_n   = 1'b1;
        inflight_n = 1'b0;
      end else begin
        pc_q_n     = pc;
        pc_n       = pc + PC_STEP;
        inflight_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      pc_q        <= 16'h0000;
      inflight    <= 1'b0;
      if_id_instr <= 16'h0000;
      if_id_pc    <= 16'h0000;
      if_id_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= 16'h0000;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      pc_q        <= pc_q_n;
      inflight    <= inflight_n;
      if_id_instr <= instr_n;
      if_id_pc    <= ipc_n;
      if_id_valid <= valid_n;
      halted      <= halted_n;
      fetch_count <= count_n;
    end
  end

endmodule
